mem_arbiter: RTL and testbench

Two-master arbiter that shares the single core-side memory port (address, byte write enables, write data, read data) in front of the Top-level address-decode crossbar. Master 0 is the CPU core. Master 1 is a debug/program loader that writes ROM/RAM images and reads memory back. The arbiter serialises one transaction at a time using round-robin fairness, an optional bounded lock for master 1, and the one-cycle read latency of the clocked ROM/RAM.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/arb_rr_picker.sv | 24 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: bus word, FSM states,
// master identifier and the latched memory request payload.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned LOCK_W = 8;

  typedef logic [DATA_W-1:0] word;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   w_en;
    word               w_data;
  } mem_req_t;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational winner selection: a lone requester always wins, a tie goes
// to master 1 under a valid lock, otherwise to the master the pointer favours.
module arb_rr_picker
  import mem_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  master_id_t ptr,
  input  logic       lock_valid,
  output master_id_t winner,
  output logic       found
);

  always_comb begin
    found  = req0 | req1;
    winner = master_id_t'(1'b0);
    if (req0 && req1) begin
      winner = lock_valid ? master_id_t'(1'b1) : ptr;
    end else if (req1) begin
      winner = master_id_t'(1'b1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU (master 0) and loader (master 1) accesses onto the single
// memory port: round-robin with a bounded lock run for master 1.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [BE_W-1:0]   m0_w_en,
  input  logic [DATA_W-1:0] m0_w_data,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [BE_W-1:0]   m1_w_en,
  input  logic [DATA_W-1:0] m1_w_data,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_r_valid,
  output logic              m1_r_valid,
  output logic [DATA_W-1:0] m0_r_data,
  output logic [DATA_W-1:0] m1_r_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_w_en,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data
);

  arb_state_t        state, state_n;
  master_id_t        owner, owner_n;
  master_id_t        ptr, ptr_n;
  master_id_t        winner;
  logic              found;
  logic              lock_valid;
  logic [LOCK_W-1:0] lock_cnt, lock_cnt_n;
  logic [LOCK_W-1:0] lock_inc;
  mem_req_t          cur, cur_n;
  mem_req_t          bus, bus_n;
  mem_req_t          m0_pkt, m1_pkt;
  logic [1:0]        gnt, gnt_n;
  logic [1:0]        rv, rv_n;

  assign m0_pkt     = {m0_addr, m0_w_en, m0_w_data};
  assign m1_pkt     = {m1_addr, m1_w_en, m1_w_data};
  assign lock_valid = m1_lock && (lock_cnt != '0);
  assign lock_inc   = lock_cnt + LOCK_W'(1);

  arb_rr_picker u_picker (
    .req0       (m0_req),
    .req1       (m1_req),
    .ptr        (ptr),
    .lock_valid (lock_valid),
    .winner     (winner),
    .found      (found)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    ptr_n      = ptr;
    cur_n      = cur;
    bus_n      = '0;
    gnt_n      = '0;
    rv_n       = '0;
    lock_cnt_n = m1_lock ? lock_cnt : '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n        = ISSUE;
          owner_n        = winner;
          cur_n          = winner ? m1_pkt : m0_pkt;
          ptr_n          = ~winner;
          gnt_n[winner]  = 1'b1;
          bus_n          = cur_n;
          // A run that reaches LOCK_MAX clears so the next tie is plain round-robin.
          if (winner && m1_lock) begin
            lock_cnt_n = (lock_inc == LOCK_W'(LOCK_MAX)) ? '0 : lock_inc;
          end else begin
            lock_cnt_n = '0;
          end
        end
      end
      ISSUE: begin
        if (cur.w_en == '0) begin
          state_n     = RESP;
          bus_n.addr  = cur.addr;
          rv_n[owner] = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= master_id_t'(1'b0);
      ptr      <= master_id_t'(1'b0);
      cur      <= '0;
      bus      <= '0;
      gnt      <= '0;
      rv       <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      cur      <= cur_n;
      bus      <= bus_n;
      gnt      <= gnt_n;
      rv       <= rv_n;
      lock_cnt <= lock_cnt_n;
    end
  end

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign m0_r_valid = rv[0];
  assign m1_r_valid = rv[1];
  assign m0_r_data  = rv[0] ? mem_r_data : '0;
  assign m1_r_data  = rv[1] ? mem_r_data : '0;
  assign mem_addr   = bus.addr;
  assign mem_w_en   = bus.w_en;
  assign mem_w_data = bus.w_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level arbitration model
// predicts grants, a shadow memory predicts read data, a monitor compares.
module tb_mem_arbiter;

  localparam int unsigned LOCK_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_w_data = '0, m1_w_data = '0;
  logic [3:0]  m0_w_en = '0, m1_w_en = '0;
  logic        m0_gnt, m1_gnt, m0_r_valid, m1_r_valid;
  logic [31:0] m0_r_data, m1_r_data, mem_addr, mem_w_data;
  logic [3:0]  mem_w_en;
  logic [31:0] mem_r_data = '0;

  mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_w_en(m0_w_en), .m0_w_data(m0_w_data),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_w_en(m1_w_en), .m1_w_data(m1_w_data),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_r_valid(m0_r_valid), .m1_r_valid(m1_r_valid),
    .m0_r_data(m0_r_data), .m1_r_data(m1_r_data),
    .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [3:0]  w_en;
    logic [31:0] w_data;
    int          cyc;
  } gexp_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    int          cyc;
  } rexp_t;

  gexp_t gnt_q[$];
  rexp_t rd_q[$];
  int    grant_log[$];
  logic [31:0] xmem   [logic [29:0]];
  logic [31:0] shadow [logic [29:0]];
  logic [31:0] last_m1_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_owner = 1;
  int run = 0;
  int next_arb = 0;
  int exp_lock[10] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] xrd(input logic [29:0] i);
    return xmem.exists(i) ? xmem[i] : 32'h0;
  endfunction

  function automatic logic [31:0] srd(input logic [29:0] i);
    return shadow.exists(i) ? shadow[i] : 32'h0;
  endfunction

  // Crossbar stand-in: byte-write RAM with one cycle of read latency.
  always begin
    @(posedge clk);
    if (mem_w_en != 4'h0) xmem[mem_addr[31:2]] = merge(xrd(mem_addr[31:2]), mem_w_en, mem_w_data);
    mem_r_data <= xrd(mem_addr[31:2]);
  end

  // Transaction-level arbitration model: one decision per free bus slot.
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      last_owner = 1;
      run        = 0;
      next_arb   = 0;
      gnt_q.delete();
      rd_q.delete();
    end else begin
      gexp_t e;
      int    w;
      bit    lock_on;
      cyc++;
      if (cyc >= next_arb && (m0_req || m1_req)) begin
        lock_on = m1_lock && run > 0 && run < int'(LOCK_MAX);
        if (m0_req && m1_req) w = lock_on ? 1 : (last_owner == 0 ? 1 : 0);
        else                  w = m1_req ? 1 : 0;
        e.m      = w;
        e.addr   = w ? m1_addr : m0_addr;
        e.w_en   = w ? m1_w_en : m0_w_en;
        e.w_data = w ? m1_w_data : m0_w_data;
        e.cyc    = cyc;
        gnt_q.push_back(e);
        next_arb   = cyc + ((e.w_en != 4'h0) ? 2 : 3);
        last_owner = w;
        if (w == 1 && m1_lock) run = (run >= int'(LOCK_MAX)) ? 1 : run + 1;
        else                   run = 0;
      end else if (!m1_lock) begin
        run = 0;
      end
    end
  end

  // Monitor: compares every grant, read return and idle bus against expectations.
  always begin
    @(negedge clk);
    if (rst_n) begin
      gexp_t ge;
      rexp_t re;
      logic  anyg, anyv;
      anyg = m0_gnt | m1_gnt;
      anyv = m0_r_valid | m1_r_valid;
      if (anyg) begin
        grant_log.push_back(m1_gnt ? 1 : 0);
        if (gnt_q.size() == 0) begin
          chk("unexpected_gnt", 32'(anyg), 32'h0);
        end else begin
          ge = gnt_q.pop_front();
          chk("gnt_pair", {m0_gnt, m1_gnt}, ge.m ? 32'h1 : 32'h2);
          chk("gnt_cycle", cyc, ge.cyc);
          chk("mem_addr", mem_addr, ge.addr);
          chk("mem_w_en", 32'(mem_w_en), 32'(ge.w_en));
          chk("mem_w_data", mem_w_data, ge.w_data);
          if (ge.w_en != 4'h0) begin
            shadow[ge.addr[31:2]] = merge(srd(ge.addr[31:2]), ge.w_en, ge.w_data);
          end else begin
            re.m = ge.m; re.data = srd(ge.addr[31:2]); re.cyc = ge.cyc + 1;
            rd_q.push_back(re);
          end
        end
      end else if (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
        chk("missing_gnt", 32'(anyg), 32'h1);
        void'(gnt_q.pop_front());
      end
      if (anyv) begin
        chk("resp_w_en", 32'(mem_w_en), 32'h0);
        if (m1_r_valid) last_m1_rdata = m1_r_data;
        if (rd_q.size() == 0) begin
          chk("unexpected_r_valid", 32'(anyv), 32'h0);
        end else begin
          re = rd_q.pop_front();
          chk("r_valid_pair", {m0_r_valid, m1_r_valid}, re.m ? 32'h1 : 32'h2);
          chk("r_valid_cycle", cyc, re.cyc);
          chk("r_data", re.m ? m1_r_data : m0_r_data, re.data);
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        chk("missing_r_valid", 32'(anyv), 32'h1);
        void'(rd_q.pop_front());
      end
      if (!anyg && !anyv) begin
        chk("idle_addr", mem_addr, 32'h0);
        chk("idle_w_en", 32'(mem_w_en), 32'h0);
        chk("idle_w_data", mem_w_data, 32'h0);
      end
      if (!m0_r_valid) chk("m0_r_data_quiet", m0_r_data, 32'h0);
      if (!m1_r_valid) chk("m1_r_data_quiet", m1_r_data, 32'h0);
    end
  end

  // Presents one request from the current negedge and holds it until granted.
  task automatic do_txn(input int m, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    int   t = 0;
    logic g;
    if (m == 0) begin m0_req = 1'b1; m0_addr = a; m0_w_en = be; m0_w_data = d; end
    else        begin m1_req = 1'b1; m1_addr = a; m1_w_en = be; m1_w_data = d; end
    do begin
      @(negedge clk);
      t++;
      g = (m == 0) ? m0_gnt : m1_gnt;
    end while (!g && t < 60);
    if (!g) chk($sformatf("timeout_m%0d", m), 32'(g), 32'h1);
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((gnt_q.size() != 0 || rd_q.size() != 0) && t < 30) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("drain_gnt_q", gnt_q.size(), 32'h0);
    chk("drain_rd_q", rd_q.size(), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_m0_gnt"}, 32'(m0_gnt), 32'h0);
    chk({tag, "_m1_gnt"}, 32'(m1_gnt), 32'h0);
    chk({tag, "_m0_r_valid"}, 32'(m0_r_valid), 32'h0);
    chk({tag, "_m1_r_valid"}, 32'(m1_r_valid), 32'h0);
    chk({tag, "_m0_r_data"}, m0_r_data, 32'h0);
    chk({tag, "_m1_r_data"}, m1_r_data, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_w_en"}, 32'(mem_w_en), 32'h0);
    chk({tag, "_mem_w_data"}, mem_w_data, 32'h0);
  endtask

  task automatic check_log(input string tag, input int n, input int first, input int alt);
    chk({tag, "_count"}, grant_log.size(), n);
    for (int i = 0; i < n && i < grant_log.size(); i++) begin
      chk($sformatf("%s_%0d", tag, i), grant_log[i], alt ? ((first + i) % 2) : exp_lock[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    xmem[30'h4]   = 32'hDEADBEEF;
    shadow[30'h4] = 32'hDEADBEEF;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ROM read by master 0
    do_txn(0, 32'h0000_0010, 4'h0, 32'h0);
    @(negedge clk);
    chk("t1_m0_r_valid", 32'(m0_r_valid), 32'h1);
    chk("t1_m0_r_data", m0_r_data, 32'hDEADBEEF);
    chk("t1_m1_r_valid", 32'(m1_r_valid), 32'h0);
    chk("t1_m1_r_data", m1_r_data, 32'h0);
    drain();

    // master 1 solo so the pointer favours master 0 again
    do_txn(1, 32'h0000_0020, 4'hF, 32'h1111_2222);
    drain();

    // simultaneous write (m0) and read-back (m1) of the same word
    grant_log.delete();
    fork
      do_txn(0, 32'h8000_0000, 4'hF, 32'hA5A5_1234);
      do_txn(1, 32'h8000_0000, 4'h0, 32'h0);
    join
    drain();
    check_log("t2_order", 2, 0, 1);
    chk("t2_m1_rdata", last_m1_rdata, 32'hA5A5_1234);

    // continuous contention without lock alternates
    grant_log.delete();
    fork
      begin for (int i = 0; i < 4; i++) do_txn(0, 32'h200 + 32'(4 * i), 4'hF, $urandom); end
      begin for (int i = 0; i < 4; i++) do_txn(1, 32'h300 + 32'(4 * i), 4'hF, $urandom); end
    join
    drain();
    check_log("t3_alt", 8, 0, 1);

    // bounded lock run of LOCK_MAX for master 1
    grant_log.delete();
    m1_lock = 1'b1;
    fork
      begin for (int i = 0; i < 3; i++) do_txn(0, 32'h400 + 32'(4 * i), 4'hF, $urandom); end
      begin for (int i = 0; i < 7; i++) do_txn(1, 32'h500 + 32'(4 * i), 4'hF, $urandom); end
    join
    m1_lock = 1'b0;
    drain();
    check_log("t4_lock", 10, 0, 0);

    // single-byte write to a top-of-space address
    do_txn(1, 32'hFFFF_FFFB, 4'b0001, 32'h1);
    chk("t5_w_en", 32'(mem_w_en), 32'h1);
    chk("t5_addr", mem_addr, 32'hFFFF_FFFB);
    @(negedge clk);
    chk("t5_w_en_drop", 32'(mem_w_en), 32'h0);
    drain();

    // reset during the response cycle of a master-0 read
    do_txn(0, 32'h0000_0010, 4'h0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    rst_n = 1'b1;
    grant_log.delete();
    fork
      do_txn(0, 32'h0000_0040, 4'hF, 32'h0BAD_F00D);
      do_txn(1, 32'h0000_0044, 4'hF, 32'h1234_5678);
    join
    drain();
    check_log("t6_after_rst", 2, 0, 1);

    // randomized traffic from both masters
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          do_txn(0, 32'h100 + 32'(4 * $urandom_range(0, 7)),
                 $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          m1_lock = 1'($urandom_range(0, 1));
          do_txn(1, 32'h100 + 32'(4 * $urandom_range(0, 7)),
                 $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
        end
      end
    join
    m1_lock = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
